// File: rtl/complex_mul_pipe.sv
// Three-stage pipelined complex multiplier: A*B or A*conj(B) in signed fixed point,
// with optional round-half-up, saturation to DATA_W and a global-stall valid/ready handshake.
module complex_mul_pipe #(
  parameter int DATA_W = 16,
  parameter int FRAC   = 8,
  parameter int ROUND  = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] a_re,
  input  logic signed [DATA_W-1:0] a_im,
  input  logic signed [DATA_W-1:0] b_re,
  input  logic signed [DATA_W-1:0] b_im,
  input  logic                     conj_b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] o_re,
  output logic signed [DATA_W-1:0] o_im,
  output logic                     o_sat,
  output logic                     sat_sticky,
  input  logic                     sat_clr
);

  localparam int PROD_W = 2 * DATA_W;
  localparam int SUM_W  = 2 * DATA_W + 1;
  localparam int RND_SH = (FRAC > 0) ? FRAC - 1 : 0;
  localparam logic signed [SUM_W-1:0] RND_C =
    (ROUND != 0 && FRAC > 0) ? (SUM_W'(1) << RND_SH) : '0;
  localparam logic signed [SUM_W-1:0] MAX_V =
    {{(SUM_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] MIN_V =
    {{(SUM_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  logic adv;

  // The only stall source is a held result; every stage moves in lockstep.
  assign adv      = !(out_valid && !out_ready);
  assign in_ready = adv;

  // Stage 1: raw products
  logic                     v1_reg;
  logic                     conj_reg;
  logic signed [PROD_W-1:0] p_rr_reg, p_ii_reg, p_ri_reg, p_ir_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_reg   <= 1'b0;
      conj_reg <= 1'b0;
      p_rr_reg <= '0;
      p_ii_reg <= '0;
      p_ri_reg <= '0;
      p_ir_reg <= '0;
    end else if (adv) begin
      v1_reg   <= in_valid;
      conj_reg <= conj_b;
      p_rr_reg <= a_re * b_re;
      p_ii_reg <= a_im * b_im;
      p_ri_reg <= a_re * b_im;
      p_ir_reg <= a_im * b_re;
    end
  end

  // Stage 2: sums at one extra bit so the two-product combination never wraps
  logic signed [SUM_W-1:0] rr_x, ii_x, ri_x, ir_x;
  logic signed [SUM_W-1:0] sum_next [2];
  logic signed [SUM_W-1:0] sum_reg  [2];
  logic                    v2_reg;

  assign rr_x = {p_rr_reg[PROD_W-1], p_rr_reg};
  assign ii_x = {p_ii_reg[PROD_W-1], p_ii_reg};
  assign ri_x = {p_ri_reg[PROD_W-1], p_ri_reg};
  assign ir_x = {p_ir_reg[PROD_W-1], p_ir_reg};

  always_comb begin
    sum_next[0] = '0;
    sum_next[1] = '0;
    if (conj_reg) begin
      sum_next[0] = rr_x + ii_x + RND_C;
      sum_next[1] = ir_x - ri_x + RND_C;
    end else begin
      sum_next[0] = rr_x - ii_x + RND_C;
      sum_next[1] = ri_x + ir_x + RND_C;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2_reg     <= 1'b0;
      sum_reg[0] <= '0;
      sum_reg[1] <= '0;
    end else if (adv) begin
      v2_reg     <= v1_reg;
      sum_reg[0] <= sum_next[0];
      sum_reg[1] <= sum_next[1];
    end
  end

  // Stage 3: scale and clamp each component (index 0 = real, 1 = imaginary)
  logic signed [DATA_W-1:0] res_next [2];
  logic                     sat_next [2];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_scale
      logic signed [SUM_W-1:0] shifted;
      logic                    over_hi, over_lo;

      assign shifted  = sum_reg[gi] >>> FRAC;
      assign over_hi  = shifted > MAX_V;
      assign over_lo  = shifted < MIN_V;
      assign sat_next[gi] = over_hi || over_lo;
      assign res_next[gi] = over_hi ? MAX_V[DATA_W-1:0] :
                            over_lo ? MIN_V[DATA_W-1:0] :
                                      shifted[DATA_W-1:0];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      o_re      <= '0;
      o_im      <= '0;
      o_sat     <= 1'b0;
    end else if (adv) begin
      out_valid <= v2_reg;
      o_re      <= res_next[0];
      o_im      <= res_next[1];
      o_sat     <= sat_next[0] || sat_next[1];
    end
  end

  // A saturated beat leaving the unit beats a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_sticky <= 1'b0;
    end else if (out_valid && out_ready && o_sat) begin
      sat_sticky <= 1'b1;
    end else if (sat_clr) begin
      sat_sticky <= 1'b0;
    end
  end

endmodule

// File: tb/tb_complex_mul_pipe.sv
// Directed bench for complex_mul_pipe: a rounding and a truncating instance share all inputs;
// a negedge monitor scores every output beat against expected values queued at acceptance.
module tb_complex_mul_pipe;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               in_valid = 1'b0;
  logic               out_ready = 1'b1;
  logic               conj_b = 1'b0;
  logic               sat_clr = 1'b0;
  logic signed [15:0] a_re = '0, a_im = '0, b_re = '0, b_im = '0;

  logic               in_ready, out_valid, o_sat, sat_sticky;
  logic signed [15:0] o_re, o_im;
  logic               in_ready_r0, out_valid_r0, o_sat_r0, sat_sticky_r0;
  logic signed [15:0] o_re_r0, o_im_r0;

  always #5 clk = ~clk;

  complex_mul_pipe #(.DATA_W(16), .FRAC(8), .ROUND(1)) dut_rnd (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im), .conj_b(conj_b),
    .out_valid(out_valid), .out_ready(out_ready), .o_re(o_re), .o_im(o_im),
    .o_sat(o_sat), .sat_sticky(sat_sticky), .sat_clr(sat_clr)
  );

  complex_mul_pipe #(.DATA_W(16), .FRAC(8), .ROUND(0)) dut_trunc (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_r0),
    .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im), .conj_b(conj_b),
    .out_valid(out_valid_r0), .out_ready(out_ready), .o_re(o_re_r0), .o_im(o_im_r0),
    .o_sat(o_sat_r0), .sat_sticky(sat_sticky_r0), .sat_clr(sat_clr)
  );

  typedef struct {
    int re1, im1, re0, im0;
    bit sat1, sat0;
    int acc_cyc, acc_stall;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   stall_cnt = 0;
  int   nout = 0;
  int   x_re1, x_im1, x_re0, x_im0;
  bit   x_sat1, x_sat0;

  task automatic check(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  // Reference for random beats: exact integer arithmetic, floor shift, clamp.
  task automatic model(input int ar, ai, br, bi, input bit cj, input bit rnd,
                       output int re, output int im, output bit sat);
    longint rr, ii, ri, ir, sr, si;
    rr = longint'(ar) * br;  ii = longint'(ai) * bi;
    ri = longint'(ar) * bi;  ir = longint'(ai) * br;
    sr = cj ? rr + ii : rr - ii;
    si = cj ? ir - ri : ri + ir;
    if (rnd) begin sr += 128; si += 128; end
    sr = sr >>> 8;
    si = si >>> 8;
    sat = 1'b0;
    if (sr > 32767)  begin sr = 32767;  sat = 1'b1; end
    if (sr < -32768) begin sr = -32768; sat = 1'b1; end
    if (si > 32767)  begin si = 32767;  sat = 1'b1; end
    if (si < -32768) begin si = -32768; sat = 1'b1; end
    re = int'(sr);
    im = int'(si);
  endtask

  // Called just after a rising edge; returns just after the edge that took the beat.
  task automatic send(input int ar, ai, br, bi, input bit cj,
                      input int re1, im1, re0, im0, input bit sat1, sat0);
    int n;
    a_re = 16'(ar); a_im = 16'(ai); b_re = 16'(br); b_im = 16'(bi); conj_b = cj;
    x_re1 = re1; x_im1 = im1; x_re0 = re0; x_im0 = im0; x_sat1 = sat1; x_sat0 = sat0;
    in_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 50);
    if (!in_ready) check("accept_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic send_rand();
    int ar, ai, br, bi, r1, i1, r0, i0;
    bit cj, s1, s0;
    ar = $urandom_range(0, 8191) - 4096;
    ai = $urandom_range(0, 8191) - 4096;
    br = $urandom_range(0, 511) - 256;
    bi = $urandom_range(0, 511) - 256;
    cj = 1'($urandom_range(0, 1));
    model(ar, ai, br, bi, cj, 1'b1, r1, i1, s1);
    model(ar, ai, br, bi, cj, 1'b0, r0, i0, s0);
    send(ar, ai, br, bi, cj, r1, i1, r0, i0, s1, s0);
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_empty", q.size(), 0);
  endtask

  // Scoreboard: values must match the queue head whenever out_valid, so held stall data is checked too.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        q.delete();
        continue;
      end
      if (out_valid) begin
        if (q.size() == 0) begin
          check("spurious_out", out_valid, 0);
        end else begin
          e = q[0];
          check("o_re", o_re, e.re1);
          check("o_im", o_im, e.im1);
          check("o_sat", o_sat, e.sat1);
          check("o_re_trunc", o_re_r0, e.re0);
          check("o_im_trunc", o_im_r0, e.im0);
          check("o_sat_trunc", o_sat_r0, e.sat0);
          check("out_valid_trunc", out_valid_r0, 1);
          if (out_ready) begin
            check("latency", cyc - e.acc_cyc, 3 + stall_cnt - e.acc_stall);
            $display("out %0d: re=%0d im=%0d sat=%0d | trunc re=%0d im=%0d",
                     nout, o_re, o_im, o_sat, o_re_r0, o_im_r0);
            nout++;
            void'(q.pop_front());
          end else begin
            check("in_ready_stall", in_ready, 0);
            stall_cnt++;
          end
        end
      end
      if (in_valid && in_ready) begin
        e.re1 = x_re1; e.im1 = x_im1; e.re0 = x_re0; e.im0 = x_im0;
        e.sat1 = x_sat1; e.sat0 = x_sat0;
        e.acc_cyc = cyc; e.acc_stall = stall_cnt;
        q.push_back(e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    int n;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_o_re", o_re, 0);
    check("rst_sticky", sat_sticky, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // identity, conjugate forms
    send(256, 0, 300, -200, 1'b0, 300, -200, 300, -200, 1'b0, 1'b0);
    send(128, 128, 128, -128, 1'b0, 128, 0, 128, 0, 1'b0, 1'b0);
    send(256, 256, 0, 256, 1'b1, 256, -256, 256, -256, 1'b0, 1'b0);
    // rounding vs truncation at the half-LSB point
    send(1, 0, 128, 0, 1'b0, 1, 0, 0, 0, 1'b0, 1'b0);
    send(-1, 0, 128, 0, 1'b0, 0, 0, -1, 0, 1'b0, 1'b0);
    idle();
    drain();
    check("sticky_clean", sat_sticky, 0);

    // saturation
    send(32767, 32767, 32767, -32767, 1'b0, 32767, 0, 32767, 0, 1'b1, 1'b1);
    idle();
    drain();
    check("sticky_set", sat_sticky, 1);
    check("sticky_set_trunc", sat_sticky_r0, 1);

    // reset with two beats held in the pipe
    out_ready = 1'b0;
    send(256, 0, 100, 50, 1'b0, 100, 50, 100, 50, 1'b0, 1'b0);
    send(256, 0, 7, -9, 1'b0, 7, -9, 7, -9, 1'b0, 1'b0);
    idle();
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("held_before_reset", out_valid, 1);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_o_re", o_re, 0);
    check("mid_rst_o_im", o_im, 0);
    check("mid_rst_o_sat", o_sat, 0);
    check("mid_rst_sticky", sat_sticky, 0);
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_out_valid_trunc", out_valid_r0, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    send(256, 0, -5, 3, 1'b0, -5, 3, -5, 3, 1'b0, 1'b0);
    idle();
    drain();

    // sticky clear
    send(32767, 32767, 32767, -32767, 1'b0, 32767, 0, 32767, 0, 1'b1, 1'b1);
    idle();
    drain();
    check("sticky_set2", sat_sticky, 1);
    sat_clr = 1'b1;
    @(posedge clk); #1;
    sat_clr = 1'b0;
    check("sticky_cleared", sat_sticky, 0);
    check("sticky_cleared_trunc", sat_sticky_r0, 0);

    // backpressure: 8 back-to-back beats with a 4-cycle output stall mid-stream
    s0 = stall_cnt;
    n = nout;
    fork
      begin
        for (int i = 0; i < 8; i++) send_rand();
        idle();
      end
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    check("stall_cycles", stall_cnt - s0, 4);
    check("stream_count", nout - n, 8);

    repeat (5) @(posedge clk);
    #1;
    check("final_queue_empty", q.size(), 0);
    check("final_out_valid", out_valid, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
